uart_tx_9bit: RTL and testbench
===============================

Name: uart_tx_9bit

Overview:
- Serial transmitter for the team's UART link, at the opposite end of the 9-bit receive path (8 data bits plus stop bit).
- Accepts one byte per handshake and serializes it as a frame: start bit (0), 8 data bits LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between the packet source logic and the serial line pin.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per bit period. Legal values are ≥ 2. The bit-period counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- tx_start  input  1  request to send tx_data; sampled only in IDLE.
- tx_data  input  8  byte to transmit; captured on the accepting edge.
- serial_out  output  1  registered serial line; idles high.
- tx_busy  output  1  registered; high from the cycle after acceptance through the last STOP cycle.
- tx_done  output  1  registered; one-cycle pulse after frame completion.

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - state=IDLE, serial_out=1, tx_busy=0, tx_done=0.
  - Bit counter, period counter and shift register all cleared.
  - Reset mid-frame abandons the frame; serial_out is 1 from the next edge.
- All outputs are registered; there are no combinational paths from input to output.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If tx_start=1, the edge loads tx_data into an 8-bit shift register, clears the period counter and moves to START.
  - At that same edge: tx_busy→1 and serial_out→0. First start-bit cycle is the cycle after tx_start is sampled (latency 1).
- START:
  - serial_out=0 for CLKS_PER_BIT cycles.
  - On period counter = CLKS_PER_BIT-1: counter→0, go to DATA, bit index→0.
- DATA:
  - serial_out = shift register bit 0.
  - At each period end: shift right one, increment bit index.
  - After the period end of bit index 7, go to STOP.
- STOP:
  - serial_out=1 for CLKS_PER_BIT cycles.
  - At period end: go to IDLE, tx_busy→0, tx_done→1 for exactly one cycle.
- Frame length: 10*CLKS_PER_BIT cycles from the first start-bit cycle to the first IDLE cycle.
- tx_start while not in IDLE is ignored; there is no queuing.
- tx_data changes after acceptance do not affect the frame in flight.
- tx_start held high in the tx_done cycle (IDLE) is accepted. Back-to-back frames therefore have exactly one idle-high cycle between stop bit and next start bit.
- tx_start held continuously high produces continuous frames, each separated by one idle cycle.
- Period and bit counters never wrap outside their defined range. Both are reset to 0 on each state entry.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - serial_out = even parity (XOR of the 8 captured data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - Parity is computed from the value captured at acceptance.
- Undefined: no PARITY state and no parity logic; frame length is 10*CLKS_PER_BIT.

Test Plan:
- Reset: n_rst=0 for 2 cycles with tx_start=1 → serial_out=1, tx_busy=0, tx_done=0 throughout; no frame starts until n_rst=1.
- Single frame, CLKS_PER_BIT=10, tx_data=8'hA5, tx_start pulsed 1 cycle:
  - Line reads 0, 1,0,1,0,0,1,0,1, 1, each held 10 cycles.
  - tx_busy high for 100 cycles.
  - tx_done pulses once, at cycle 101 after the start.
- Ignore while busy: tx_start=1 with tx_data=8'hFF at cycle 30 of an 8'h00 frame → 8'h00 frame completes unchanged, no second frame.
- Back-to-back: tx_start held high with tx_data=8'h3C then 8'hC3 → second start bit begins exactly 1 cycle after the first frame's stop bit ends; both bytes are decoded correctly by the team's receiver on the looped-back line.
- Mid-frame reset: n_rst=0 during DATA bit 4 of 8'h55 → next edge serial_out=1, tx_busy=0, no tx_done; a fresh 8'h0F after reset transmits correctly.
- With UART_TX_PARITY_EN: tx_data=8'h07 → parity bit 1 and frame 110 cycles; tx_data=8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_9bit.sv
// rtl/uart_tx_9bit.sv - 8N1 UART transmitter with registered outputs.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_9bit #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic period_end;
  assign period_end = (cnt_q == CNT_LAST);

  // serial_out is registered, so each transition loads the level of the state being entered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d  = tx_data;
          cnt_d    = '0;
          bit_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d  = S_START;
          busy_d   = 1'b1;
          out_d    = 1'b0;
        end
      end
      S_START: begin
        if (period_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          out_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (period_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            out_d   = parity_q;
`else
            state_d = S_STOP;
            out_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            out_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (period_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (period_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
        out_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      out_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out = out_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_9bit.sv
// tb/tb_uart_tx_9bit.sv - bench for uart_tx_9bit against a per-cycle line model.
// Honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx_9bit;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_9bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  // Line level of frame slot idx: start, d[0..7], optional even parity, stop
  function automatic logic exp_line(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (NBITS == 11 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s line %0d", tag, i), serial_out, 1'b1);
      chk($sformatf("%s busy %0d", tag, i), tx_busy, 1'b0);
      chk($sformatf("%s done %0d", tag, i), tx_done, 1'b0);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
  endtask

  // Called one cycle after the accepting edge; returns at the tx_done cycle.
  task automatic check_frame(input logic [7:0] d, input bit keep, input logic [7:0] next_d,
                             input int poke);
    for (int c = 1; c <= FL; c++) begin
      tx_start = keep || (c == poke);
      tx_data  = (c == poke) ? 8'hFF : (keep ? next_d : 8'($urandom));
      chk($sformatf("frame %02h line c%0d", d, c), serial_out, exp_line(d, (c - 1) / CPB));
      chk($sformatf("frame %02h busy c%0d", d, c), tx_busy, 1'b1);
      chk($sformatf("frame %02h done c%0d", d, c), tx_done, 1'b0);
      tick();
    end
    chk($sformatf("frame %02h end line", d), serial_out, 1'b1);
    chk($sformatf("frame %02h end busy", d), tx_busy, 1'b0);
    chk($sformatf("frame %02h end done", d), tx_done, 1'b1);
    tx_start = keep;
    if (keep) tx_data = next_d;
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         k;

    n_rst    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset line", serial_out, 1'b1);
      chk("reset busy", tx_busy, 1'b0);
      chk("reset done", tx_done, 1'b0);
    end
    n_rst    = 1'b1;
    tx_start = 1'b0;
    idle_cycles(3, "post reset");

    send(8'hA5);
    check_frame(8'hA5, 1'b0, 8'h00, 0);
    idle_cycles(5, "after A5");

    // Request during frame must be dropped, not queued
    send(8'h00);
    check_frame(8'h00, 1'b0, 8'h00, 30);
    idle_cycles(FL + 5, "no second frame");

    send(8'h3C);
    check_frame(8'h3C, 1'b1, 8'hC3, 0);
    send(8'hC3);
    check_frame(8'hC3, 1'b0, 8'h00, 0);
    idle_cycles(3, "after C3");

    send(8'h55);
    tx_start = 1'b0;
    for (int c = 1; c < 55; c++) tick();
    chk("mid reset data bit 4", serial_out, 1'b1);
    chk("mid reset busy before", tx_busy, 1'b1);
    n_rst = 1'b0;
    tick();
    chk("mid reset line", serial_out, 1'b1);
    chk("mid reset busy", tx_busy, 1'b0);
    chk("mid reset done", tx_done, 1'b0);
    tick();
    n_rst = 1'b1;
    idle_cycles(FL, "after mid reset");
    send(8'h0F);
    check_frame(8'h0F, 1'b0, 8'h00, 0);
    idle_cycles(2, "after 0F");

    send(8'h07);
    check_frame(8'h07, 1'b0, 8'h00, 0);
    send(8'h03);
    check_frame(8'h03, 1'b0, 8'h00, 0);
    idle_cycles(2, "after parity frames");

    cur = 8'($urandom);
    send(cur);
    for (int i = 0; i < 6; i++) begin
      nxt = 8'($urandom);
      k   = 1'($urandom_range(0, 1));
      check_frame(cur, k, nxt, 0);
      if (!k) idle_cycles($urandom_range(1, 4), "random gap");
      send(nxt);
      cur = nxt;
    end
    check_frame(cur, 1'b0, 8'h00, 0);
    idle_cycles(2, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
